jtframe_rom_arb: RTL
====================

# jtframe_rom_arb

Parametrised N-channel round-robin arbiter between game-side ROM fetchers and the single SDRAM request port (`sdram_req`/`sdram_ack`/`data_rdy`) of the board SDRAM controller. It replaces the one-requester hook-up with CHANNELS independent requesters, each with its own handshake and completion strobe. It sits in the game clock domain between the game ROM readers and the board SDRAM controller. Transfers stall while `downloading` is high and abort cleanly on `loop_rst`.

## Interface
Parameters:
- CHANNELS, 4, number of requesters (2..8).
- AW, 22, SDRAM word address width.
- DW, 32, read data width.
- TIMEOUT, 1023, watchdog limit in cycles; used only with JTFRAME_ARB_TIMEOUT_EN.

Ports (one clock; reset is synchronous and active-high):
- clk_rom  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- loop_rst  in  1  SDRAM controller init in progress; treated exactly as rst.
- downloading  in  1  ROM download active; blocks new grants.
- ch_req  in  CHANNELS  per-channel request level.
- ch_addr  in  CHANNELS*AW  flattened addresses; channel i at [i*AW +: AW].
- ch_bank  in  CHANNELS*2  flattened bank selects.
- ch_ack  out  CHANNELS  one-cycle pulse: request accepted by SDRAM.
- ch_data_ok  out  CHANNELS  one-cycle pulse: ch_dout valid for this channel.
- ch_dout  out  DW  shared read data, registered.
- sdram_req  out  1  request to controller.
- sdram_addr  out  AW  latched address.
- sdram_bank  out  2  latched bank.
- sdram_ack  in  1  controller accepted request.
- data_read  in  DW  controller read data.
- data_rdy  in  1  controller data valid strobe.
- busy  out  1  arbiter not in IDLE.
- timeout_err  out  1  sticky watchdog flag (0 if macro absent).

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: if downloading=0 and any ch_req, grant the first requesting channel strictly after `last` (round-robin, wrapping CHANNELS-1 -> 0). Latch its addr/bank and index, set `last`, go to REQ.
- REQ: sdram_req=1 with latched addr/bank. On sdram_ack: pulse ch_ack[g], drop sdram_req, go to WAIT.
- WAIT: on data_rdy, register data_read into ch_dout, go to DONE.
- DONE: ch_data_ok[g]=1 for this cycle only, then return to IDLE.
- Channels hold ch_req until ch_ack. A request dropped before grant is never served. ch_req may stay high after ch_ack to queue the next read.
- ch_dout holds its value until the next data_rdy.
- downloading rising in REQ: drop sdram_req and go to IDLE without ch_ack. In WAIT: finish the pending data_rdy normally.
- rst or loop_rst: reset every state and output immediately, including mid-transfer. No ack/data_ok pulses are issued for an aborted transfer.

## Timing
- Reset values: state IDLE, sdram_req 0, sdram_addr 0, sdram_bank 0, ch_ack 0, ch_data_ok 0, ch_dout 0, busy 0, timeout_err 0, last=CHANNELS-1 (channel 0 wins the first tie).
- Request seen in IDLE at edge N -> sdram_req high from N+1.
- sdram_ack sampled at edge M -> ch_ack pulse and sdram_req low during cycle M+1.
- data_rdy at edge K -> ch_dout updated and ch_data_ok high during cycle K+1 (single cycle).
- Minimum turnaround: a new grant is possible in the IDLE cycle following DONE.
- sdram_ack and data_rdy in the same cycle while in REQ: ack is taken and data_rdy is ignored (the controller guarantees data after ack).

## Configuration
- JTFRAME_ARB_TIMEOUT_EN defined: a counter runs in REQ/WAIT and clears on each state change. When it reaches TIMEOUT: drop sdram_req, set timeout_err (sticky until rst), return to IDLE with no pulses.
- Undefined: no counter, timeout_err tied 0, the arbiter waits indefinitely.

## Test plan
- Single channel: ch_req[2]=1, addr 0x12345; ack 3 cycles later, data_rdy 5 cycles after ack with 0xDEADBEEF -> sdram_addr=0x12345, one ch_ack[2] pulse, ch_dout=0xDEADBEEF with one ch_data_ok[2] pulse.
- All four requesting continuously after reset -> grant order 0,1,2,3,0; no channel served twice before the others.
- downloading=1 while ch_req[1]=1 -> sdram_req stays 0. Release downloading -> grant at the next cycle.
- rst asserted during WAIT -> all outputs 0 next cycle. A later data_rdy produces no ch_data_ok.
- With macro, TIMEOUT=15 and no sdram_ack -> sdram_req drops after 15 cycles, timeout_err=1, and the next request is served normally.

Source files
------------

// File: rtl/jtframe_rom_arb.sv
// jtframe_rom_arb: round-robin arbiter that lets CHANNELS game-side ROM
// fetchers share the single request port of the board SDRAM controller.
// The winner's address and bank are latched, and its ch_ack/ch_data_ok
// strobes are routed back to it.
// Optional build macro: JTFRAME_ARB_TIMEOUT_EN adds a REQ/WAIT watchdog
// that abandons a stuck transfer and raises a sticky timeout_err.
module jtframe_rom_arb #(
    parameter int CHANNELS = 4,
    parameter int AW       = 22,
    parameter int DW       = 32,
    parameter int TIMEOUT  = 1023
) (
    input  logic                   clk_rom,
    input  logic                   rst,
    input  logic                   loop_rst,
    input  logic                   downloading,
    input  logic [CHANNELS-1:0]    ch_req,
    input  logic [CHANNELS*AW-1:0] ch_addr,
    input  logic [CHANNELS*2-1:0]  ch_bank,
    output logic [CHANNELS-1:0]    ch_ack,
    output logic [CHANNELS-1:0]    ch_data_ok,
    output logic [DW-1:0]          ch_dout,
    output logic                   sdram_req,
    output logic [AW-1:0]          sdram_addr,
    output logic [1:0]             sdram_bank,
    input  logic                   sdram_ack,
    input  logic [DW-1:0]          data_read,
    input  logic                   data_rdy,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    bank;
    } rom_req_t;

    state_t              state, nx_state;
    rom_req_t            req_arr [CHANNELS];
    rom_req_t            req_q;
    logic [IW-1:0]       last, gnt, pick;
    logic                pick_vld;
    logic                srst;
    logic                tmo;
    logic [CHANNELS-1:0] ack_q;
    logic [DW-1:0]       dout_q;

    // loop_rst (controller init) aborts everything exactly like rst
    assign srst = rst | loop_rst;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            assign req_arr[gi]    = {ch_addr[gi*AW +: AW], ch_bank[gi*2 +: 2]};
            assign ch_data_ok[gi] = (state == DONE) && (gnt == IW'(gi));
        end
    endgenerate

    // Round-robin search: first requester strictly after the last winner
    always_comb begin
        int unsigned c;
        c        = 0;
        pick     = last;
        pick_vld = 1'b0;
        for (int k = 1; k <= CHANNELS; k++) begin
            c = int'(last) + k;
            if (c >= CHANNELS) c = c - CHANNELS;
            if (!pick_vld && ch_req[c[IW-1:0]]) begin
                pick     = c[IW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    // Next-state: grant, wait for ack, wait for data, one DONE cycle
    always_comb begin
        nx_state = state;
        case (state)
            IDLE: if (!downloading && pick_vld) nx_state = REQ;
            // an accepted request must complete, so ack wins over downloading
            REQ:  if (sdram_ack)        nx_state = WAIT;
                  else if (downloading) nx_state = IDLE;
            // data_rdy is only honoured here, never in REQ
            WAIT: if (data_rdy)         nx_state = DONE;
            DONE:                       nx_state = IDLE;
            default:                    nx_state = IDLE;
        endcase
        if (tmo) nx_state = IDLE;
    end

    // State register
    always_ff @(posedge clk_rom) begin
        if (srst) state <= IDLE;
        else      state <= nx_state;
    end

    // Grant latch, ack pulse and read-data register
    always_ff @(posedge clk_rom) begin
        if (srst) begin
            gnt    <= '0;
            last   <= IW'(CHANNELS-1);
            req_q  <= '0;
            ack_q  <= '0;
            dout_q <= '0;
        end else begin
            ack_q <= '0;
            if (state == IDLE && nx_state == REQ) begin
                gnt   <= pick;
                last  <= pick;
                req_q <= req_arr[pick];
            end
            if (state == REQ && nx_state == WAIT) ack_q[gnt] <= 1'b1;
            if (state == WAIT && nx_state == DONE) dout_q <= data_read;
        end
    end

`ifdef JTFRAME_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT+1) : 1;

    logic [CW-1:0] cnt;
    logic          terr;

    // tmo fires on the TIMEOUT-th cycle spent in the same REQ/WAIT state
    assign tmo = (state == REQ || state == WAIT) && (cnt == CW'(TIMEOUT-1));

    // Watchdog counter, cleared on every state change; sticky error flag
    always_ff @(posedge clk_rom) begin
        if (srst) begin
            cnt  <= '0;
            terr <= 1'b0;
        end else begin
            if (state != nx_state || !(state == REQ || state == WAIT)) cnt <= '0;
            else                                                       cnt <= cnt + 1'b1;
            if (tmo) terr <= 1'b1;
        end
    end

    assign timeout_err = terr;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign tmo            = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    assign sdram_req  = (state == REQ);
    assign sdram_addr = req_q.addr;
    assign sdram_bank = req_q.bank;
    assign ch_ack     = ack_q;
    assign ch_dout    = dout_q;
    assign busy       = (state != IDLE);

endmodule
